corefifo_wr_ptr_gen: RTL and testbench
======================================

Name: corefifo_wr_ptr_gen

Overview:
Write-domain pointer and flag generator for the async COREFIFO. Produces the binary RAM write address and the registered Gray write pointer that crosses into the read domain. It also synchronises the incoming read Gray pointer, converts it to binary, and derives full, almost-full, write count, ack and overflow. It feeds the read-side Gray-to-binary converter and consumes the read-side Gray pointer.

Parameters:
ADDRWIDTH, 3, RAM address width; FIFO depth = 2**ADDRWIDTH; pointers are ADDRWIDTH+1 bits
AFULL_THRESH, 6, afull asserts when occupancy >= this value (legal range 1..2**ADDRWIDTH)
SYNC_STAGES, 2, flop stages on the read-pointer crossing (minimum 2)

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  synchronous, active-low reset
we  in  1  write request
rd_gray_async  in  ADDRWIDTH+1  read Gray pointer from the read domain, asynchronous to wclk
ram_we  out  1  RAM write strobe
wr_addr  out  ADDRWIDTH  RAM write address
wr_gray  out  ADDRWIDTH+1  registered Gray write pointer, to the read domain
full  out  1  FIFO full
afull  out  1  occupancy >= AFULL_THRESH
wr_cnt  out  ADDRWIDTH+1  write-side occupancy, pessimistic
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected

Behaviour:
- Interface (already decided): one clock, wclk. Reset wrst_n is synchronous and active-low.
- Reset: all flops clear on the wclk edge with wrst_n=0. This covers wr_bin, wr_gray, sync chain, full, afull, wr_cnt, wr_ack and overflow. ram_we is 0 while in reset.
- Reset mid-operation: takes precedence over a simultaneous we. Pointers return to 0 and no ack is generated.
- Accept = we & ~full & wrst_n. ram_we = accept (combinational). wr_addr = wr_bin[ADDRWIDTH-1:0] (current value, registered source).
- On accept:
  - wr_bin <= wr_bin + 1, modulo 2**(ADDRWIDTH+1).
  - wr_gray <= bin2gray(wr_bin + 1), loaded directly from the next-binary value. wr_gray is a flop output with no glitching logic. Exactly 1 bit changes per increment, including the wrap.
- Read-pointer crossing: rd_gray_async passes through SYNC_STAGES flops. The last stage is converted: rd_bin = gray2bin(sync_out). The conversion is combinational: MSB passes through, each lower bit = higher binary bit XOR own Gray bit.
- Occupancy next: cnt_n = (wr_bin_next - rd_bin), modulo 2**(ADDRWIDTH+1). wr_bin_next = wr_bin + accept.
- Flag registers:
  - full <= (cnt_n == 2**ADDRWIDTH).
  - afull <= (cnt_n >= AFULL_THRESH).
  - wr_cnt <= cnt_n.
- Latencies:
  - full asserts on the edge that accepts the last word, so the next cycle has full=1 and no over-write is possible.
  - full deasserts SYNC_STAGES+1 wclk edges after rd_gray_async changes. This is pessimistic and safe.
- wr_ack <= accept. overflow <= we & full. These are 1-cycle pulses, 1 cycle after the request, and mutually exclusive.
- Write while full: pointer, wr_gray and ram_we are unchanged; overflow pulses.
- Simultaneous write and read-pointer advance in the same cycle: both are reflected in cnt_n, so occupancy stays constant.
- Wrap-around: wr_bin 2**(ADDRWIDTH+1)-1 -> 0. For ADDRWIDTH=3, wr_gray goes 0x8 -> 0x0. The full/empty distinction is held by the extra MSB.

Decomposition:
- Package corefifo_pkg:
  - function bin2gray(b) = b ^ (b >> 1).
  - function gray2bin, an iterative XOR from the MSB down.
  - constant PTRW = ADDRWIDTH+1.
  - constant DEPTH = 2**ADDRWIDTH.
- One sub-module: corefifo_sync_nff. It is a parameterised-width, SYNC_STAGES-deep synchronous-reset flop chain clocked by wclk, used for the rd_gray_async crossing. It is reusable for the mirrored read-side block.

Test Plan:
- Fill from reset, ADDRWIDTH=3, rd_gray_async=0, we=1 for 8 cycles:
  - wr_addr 0..7 and wr_gray sequence 0,1,3,2,6,7,5,4,0xC.
  - afull=1 after the 6th accept.
  - full=1 in the cycle after the 8th accept; wr_cnt=8.
- Overflow: with full=1, assert we for 1 cycle -> overflow=1 for 1 cycle, wr_ack=0, ram_we=0, wr_gray stays 0xC.
- Read release: full, then rd_gray_async=0x2 (bin 3) -> full=0, wr_cnt=5, afull=0 exactly 3 edges later (SYNC_STAGES=2).
- Wrap: run 15 accepted writes with reads tracking, then 1 more -> wr_gray 0x8 -> 0x0, wr_bin 15 -> 0. full stays 0. Exactly 1 wr_gray bit toggles per accept throughout the run.
- Simultaneous: occupancy 4; we=1 while rd_gray_async advances by one -> wr_cnt stays 4 after the sync latency. No spurious afull or full.
- Reset mid-fill: after 5 writes assert wrst_n=0 for 1 cycle with we=1 -> next cycle all outputs 0, no wr_ack. A write after release uses wr_addr=0.

Source files
------------

// File: rtl/corefifo_pkg.sv
// Shared constants and pointer-code helpers for the COREFIFO pointer generators.
// The helpers work on a wide word so any pointer width can zero-extend into them.
package corefifo_pkg;

  localparam int ADDRWIDTH_DFLT = 3;
  localparam int PTRW           = ADDRWIDTH_DFLT + 1;
  localparam int DEPTH          = 2 ** ADDRWIDTH_DFLT;
  localparam int FUNCW          = 32;

  typedef logic [FUNCW-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits stay zero through the XOR chain, so narrow pointers convert correctly.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[FUNCW-1] = g[FUNCW-1];
    for (int i = FUNCW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/corefifo_wr_ptr_gen_if.sv
// Write-side bus of the COREFIFO pointer generator: write request, read-pointer input,
// RAM strobe/address, Gray pointer to the read domain and the status flags.
interface corefifo_wr_ptr_gen_if
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH = ADDRWIDTH_DFLT
);

  logic                 we;
  logic [ADDRWIDTH:0]   rd_gray_async;
  logic                 ram_we;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [ADDRWIDTH:0]   wr_gray;
  logic                 full;
  logic                 afull;
  logic [ADDRWIDTH:0]   wr_cnt;
  logic                 wr_ack;
  logic                 overflow;

  modport master (
    output we, rd_gray_async,
    input  ram_we, wr_addr, wr_gray, full, afull, wr_cnt, wr_ack, overflow
  );

  modport slave (
    input  we, rd_gray_async,
    output ram_we, wr_addr, wr_gray, full, afull, wr_cnt, wr_ack, overflow
  );

endinterface

// File: rtl/corefifo_sync_nff.sv
// Multi-flop synchroniser with synchronous active-low reset, used for Gray pointer crossings
// in either direction.
module corefifo_sync_nff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/corefifo_wr_ptr_gen.sv
// Write-domain pointer and flag generator of the async COREFIFO: binary RAM address,
// registered Gray write pointer, and full/afull/count/ack/overflow from the synchronised read pointer.
module corefifo_wr_ptr_gen
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH    = ADDRWIDTH_DFLT,
  parameter int AFULL_THRESH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input logic                   wclk,
  input logic                   wrst_n,
  corefifo_wr_ptr_gen_if.slave  bus
);

  localparam int            PW        = ADDRWIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT  = PW'(2 ** ADDRWIDTH);
  localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wrBin;
  logic [PW-1:0] r_wrGray;
  logic [PW-1:0] r_wrCnt;
  logic          r_full;
  logic          r_afull;
  logic          r_wrAck;
  logic          r_overflow;

  logic          w_accept;
  logic [PW-1:0] w_wrBinInc;
  logic [PW-1:0] w_wrBinNext;
  logic [PW-1:0] w_rdGraySync;
  logic [PW-1:0] w_rdBin;
  logic [PW-1:0] w_cntNext;

  corefifo_sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .i_clk   (wclk),
    .i_rst_n (wrst_n),
    .i_d     (bus.rd_gray_async),
    .o_q     (w_rdGraySync)
  );

  // Reset gates the accept so a write coinciding with reset never strobes the RAM.
  assign w_accept    = bus.we & ~r_full & wrst_n;
  assign w_wrBinInc  = r_wrBin + PW'(1);
  assign w_wrBinNext = w_accept ? w_wrBinInc : r_wrBin;
  assign w_rdBin     = PW'(gray2bin(FUNCW'(w_rdGraySync)));
  assign w_cntNext   = w_wrBinNext - w_rdBin;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wrBin    <= '0;
      r_wrGray   <= '0;
      r_wrCnt    <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_wrAck    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrBin  <= w_wrBinInc;
        r_wrGray <= PW'(bin2gray(FUNCW'(w_wrBinInc)));
      end
      // Occupancy uses the stale read pointer, so full clears late but never early.
      r_full     <= (w_cntNext == FULL_CNT);
      r_afull    <= (w_cntNext >= AFULL_CNT);
      r_wrCnt    <= w_cntNext;
      r_wrAck    <= w_accept;
      r_overflow <= bus.we & r_full;
    end
  end

  assign bus.ram_we   = w_accept;
  assign bus.wr_addr  = r_wrBin[ADDRWIDTH-1:0];
  assign bus.wr_gray  = r_wrGray;
  assign bus.full     = r_full;
  assign bus.afull    = r_afull;
  assign bus.wr_cnt   = r_wrCnt;
  assign bus.wr_ack   = r_wrAck;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_corefifo_wr_ptr_gen.sv
// Directed bench for corefifo_wr_ptr_gen: a vector table for fill/overflow/release,
// then hand-written wrap, simultaneous read/write and reset-mid-fill sequences.
module tb_corefifo_wr_ptr_gen;
  import corefifo_pkg::*;

  localparam int AW = ADDRWIDTH_DFLT;

  typedef struct packed {
    logic            rstN;
    logic            we;
    logic [PTRW-1:0] rdGray;
    logic            expRamWe;
    logic [AW-1:0]   expAddr;
    logic [PTRW-1:0] expGray;
    logic            expFull;
    logic            expAfull;
    logic [PTRW-1:0] expCnt;
    logic            expAck;
    logic            expOvf;
  } vec_t;

  localparam int NVEC = 14;

  logic wclk;
  logic wrst_n;
  int   nChecks;
  int   nFails;
  vec_t vecs [NVEC];

  corefifo_wr_ptr_gen_if #(.ADDRWIDTH(AW)) bus ();

  corefifo_wr_ptr_gen #(
    .ADDRWIDTH    (AW),
    .AFULL_THRESH (6),
    .SYNC_STAGES  (2)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic rstN, input logic we, input logic [PTRW-1:0] rd);
    @(negedge wclk);
    wrst_n            = rstN;
    bus.we            = we;
    bus.rd_gray_async = rd;
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  function automatic logic [PTRW-1:0] toGray(input int b);
    int g;
    g = (b ^ (b >> 1)) & (2 * DEPTH - 1);
    return g[PTRW-1:0];
  endfunction

  initial begin
    logic [PTRW-1:0] prevGray;
    int              m;

    nChecks = 0;
    nFails  = 0;

    //          rstN we  rd    ramWe addr gray  full afull cnt   ack  ovf
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd1, 4'h1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd2, 4'h3, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd3, 4'h2, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd4, 4'h6, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd5, 4'h7, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd6, 4'h5, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 1'b1, 3'd7, 4'h4, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'h2, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'h2, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'h2, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'h2, 1'b0, 3'd0, 4'hC, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0};

    wrst_n            = 1'b0;
    bus.we            = 1'b0;
    bus.rd_gray_async = '0;

    $display("[TB] reset state");
    resetDut();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("reset ram_we",   bus.ram_we,   0);
    checkOutput("reset wr_addr",  bus.wr_addr,  0);
    checkOutput("reset wr_gray",  bus.wr_gray,  0);
    checkOutput("reset full",     bus.full,     0);
    checkOutput("reset afull",    bus.afull,    0);
    checkOutput("reset wr_cnt",   bus.wr_cnt,   0);
    checkOutput("reset wr_ack",   bus.wr_ack,   0);
    checkOutput("reset overflow", bus.overflow, 0);

    $display("[TB] fill, overflow and read release table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].we, vecs[i].rdGray);
      checkOutput($sformatf("vec%0d ram_we", i),   bus.ram_we,   vecs[i].expRamWe);
      checkOutput($sformatf("vec%0d wr_addr", i),  bus.wr_addr,  vecs[i].expAddr);
      checkOutput($sformatf("vec%0d wr_gray", i),  bus.wr_gray,  vecs[i].expGray);
      checkOutput($sformatf("vec%0d full", i),     bus.full,     vecs[i].expFull);
      checkOutput($sformatf("vec%0d afull", i),    bus.afull,    vecs[i].expAfull);
      checkOutput($sformatf("vec%0d wr_cnt", i),   bus.wr_cnt,   vecs[i].expCnt);
      checkOutput($sformatf("vec%0d wr_ack", i),   bus.wr_ack,   vecs[i].expAck);
      checkOutput($sformatf("vec%0d overflow", i), bus.overflow, vecs[i].expOvf);
    end

    $display("[TB] wrap with reads tracking");
    resetDut();
    m        = 0;
    prevGray = '0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b1, toGray(m));
      if (k > 0) checkOutput($sformatf("wrap%0d one-bit", k), $countones(bus.wr_gray ^ prevGray), 1);
      checkOutput($sformatf("wrap%0d wr_addr", k), bus.wr_addr, m % DEPTH);
      checkOutput($sformatf("wrap%0d wr_gray", k), bus.wr_gray, toGray(m));
      checkOutput($sformatf("wrap%0d full", k),    bus.full,    0);
      prevGray = bus.wr_gray;
      m++;
    end
    checkOutput("wrap pre-wrap gray", prevGray, 4'h8);
    applyStimulus(1'b1, 1'b0, toGray(m));
    checkOutput("wrap final one-bit", $countones(bus.wr_gray ^ prevGray), 1);
    checkOutput("wrap final wr_gray", bus.wr_gray, 0);
    checkOutput("wrap final wr_addr", bus.wr_addr, 0);
    checkOutput("wrap final full",    bus.full,    0);

    $display("[TB] simultaneous write and read advance");
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, '0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("simul start wr_cnt", bus.wr_cnt, 4);
    applyStimulus(1'b1, 1'b1, toGray(1));
    checkOutput("simul ram_we", bus.ram_we, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, toGray(1));
      checkOutput($sformatf("simul%0d afull", k), bus.afull, 0);
      checkOutput($sformatf("simul%0d full", k),  bus.full,  0);
    end
    checkOutput("simul end wr_cnt", bus.wr_cnt, 4);

    $display("[TB] reset mid-fill");
    resetDut();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, '0);
    checkOutput("midrst pre wr_addr", bus.wr_addr, 4);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("midrst ram_we in reset", bus.ram_we, 0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("midrst wr_addr",  bus.wr_addr,  0);
    checkOutput("midrst wr_gray",  bus.wr_gray,  0);
    checkOutput("midrst full",     bus.full,     0);
    checkOutput("midrst afull",    bus.afull,    0);
    checkOutput("midrst wr_cnt",   bus.wr_cnt,   0);
    checkOutput("midrst wr_ack",   bus.wr_ack,   0);
    checkOutput("midrst overflow", bus.overflow, 0);
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput("midrst post ram_we",  bus.ram_we,  1);
    checkOutput("midrst post wr_addr", bus.wr_addr, 0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("midrst post wr_ack",  bus.wr_ack,  1);
    checkOutput("midrst next wr_addr", bus.wr_addr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
